pattern_player: RTL and testbench
=================================

PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 Parameter WIDTH, default 5, stimulus vector width driven to the DUT.
REQ-002 Parameter OUT_W, default 1, DUT response width.
REQ-003 Parameter DEPTH, default 8, number of vector slots (power of two, at least 2).
REQ-004 Parameter HOLD_W, default 8, width of the per-vector hold count.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port list (name, direction, width, meaning); the block SHALL provide:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- load_valid, in, 1, load-entry valid.
- load_ready, out, 1, accepts an entry; high only in IDLE while not full.
- load_vec, in, WIDTH, stimulus vector.
- load_exp, in, OUT_W, expected response.
- load_hold, in, HOLD_W, hold cycles; 0 is treated as 1.
- load_mask, in, 1, 1 = do not check this entry (monitor-off window).
- start, in, 1, one-cycle pulse that begins playback.
- clear, in, 1, one-cycle pulse that empties the table and counters.
- dut_in, out, WIDTH, stimulus to the DUT (registered).
- dut_out, in, OUT_W, DUT response.
- busy, out, 1, high in PLAY.
- done, out, 1, one-cycle pulse when playback ends.
- vec_idx, out, $clog2(DEPTH), index of the entry being applied.
- err_count, out, $clog2(DEPTH)+1, mismatches counted.
- first_err_valid, out, 1, at least one mismatch has occurred.
- first_err_idx, out, $clog2(DEPTH), index of the first mismatch.

Function
REQ-007 Entries SHALL load on load_valid && load_ready into slot wr_ptr, which then increments; count saturates at DEPTH and load_ready drops.
REQ-008 The FSM SHALL have three states: IDLE, PLAY, END.
- IDLE -> PLAY on start when count > 0.
- start with count == 0 SHALL go to END, producing done with err_count = 0.
REQ-009 On entering PLAY, dut_in SHALL show slot 0 on the next cycle, with vec_idx = 0; each slot SHALL be held max(load_hold, 1) cycles.
REQ-010 On the last hold cycle of an unmasked slot, dut_out SHALL be compared with load_exp.
- A mismatch increments err_count.
- On the first mismatch, first_err_idx and first_err_valid SHALL also be set.
REQ-011 Masked slots SHALL never be compared or counted.
REQ-012 After the last slot (index count-1), the FSM SHALL enter END.
- done pulses for exactly one cycle.
- The FSM then returns to IDLE.
- dut_in holds the final vector.
REQ-013 start during PLAY or END SHALL be ignored; load_valid outside IDLE SHALL be ignored and load_ready is 0.
REQ-014 The table SHALL persist across runs; a new start SHALL zero err_count and first_err_valid in the same cycle it leaves IDLE.
REQ-015 clear in IDLE SHALL zero count, wr_ptr and the error outputs; clear outside IDLE SHALL be ignored.
- If clear and load_valid are asserted together, clear wins.
REQ-016 err_count SHALL saturate at DEPTH.

Reset
REQ-017 When rst is high at a clock edge, the block SHALL go to IDLE and set:
- dut_in = 0, vec_idx = 0, count = 0, wr_ptr = 0.
- err_count = 0, first_err_valid = 0, first_err_idx = 0.
- busy = 0, done = 0, load_ready = 1.
REQ-018 Reset asserted mid-PLAY SHALL abort playback without a done pulse.
REQ-019 Slot storage SHALL need no reset.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding and the default parameter values.
REQ-021 The vector table (vec, exp, hold, mask per slot) SHALL be a separate sub-module, pattern_table: one write port and one read port with asynchronous read.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Load the 4 entries 00000, 10101, 11011, 11111, each with hold 10, unmasked, and a correct model DUT; then start -> each vector is held 10 cycles, done arrives 40 cycles after the first vector appears, err_count = 0.
- Same table, with the DUT forced wrong on entry 2 -> err_count = 1, first_err_idx = 2, first_err_valid = 1.
- Mask entries 1-2 with a DUT wrong on both -> err_count = 0.
- Load DEPTH+1 entries -> load_ready = 0 after the 8th, the 9th is not accepted, and playback covers 8 vectors.
- Assert rst in the middle of entry 1 -> the next cycle shows IDLE, dut_in = 0, no done pulse; start with count == 0 -> done on the next cycle, err_count = 0.
- Entry with hold 0 -> held 1 cycle; start pulsed during PLAY -> no effect.

Source files
------------

// File: rtl/pattern_player_pkg.sv
// Shared definitions for the pattern player: playback FSM encoding and the
// default parameter values used by the top and the vector table.
package pattern_player_pkg;

   localparam int DEF_WIDTH  = 5;
   localparam int DEF_OUT_W  = 1;
   localparam int DEF_DEPTH  = 8;
   localparam int DEF_HOLD_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_END  = 2'd2
   } state_t;

endpackage

// File: rtl/pattern_table.sv
// Vector table for the pattern player: one synchronous write port and one
// asynchronous read port. Storage is deliberately left without reset.
module pattern_table
   import pattern_player_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int OUT_W  = DEF_OUT_W,
   parameter int HOLD_W = DEF_HOLD_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_vec,
   input  logic [OUT_W-1:0]         wr_exp,
   input  logic [HOLD_W-1:0]        wr_hold,
   input  logic                     wr_mask,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_vec,
   output logic [OUT_W-1:0]         rd_exp,
   output logic [HOLD_W-1:0]        rd_hold,
   output logic                     rd_mask
);

   logic [WIDTH-1:0]  vec_mem_r  [DEPTH];
   logic [OUT_W-1:0]  exp_mem_r  [DEPTH];
   logic [HOLD_W-1:0] hold_mem_r [DEPTH];
   logic              mask_mem_r [DEPTH];

   // Slot write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         vec_mem_r[wr_addr]  <= wr_vec;
         exp_mem_r[wr_addr]  <= wr_exp;
         hold_mem_r[wr_addr] <= wr_hold;
         mask_mem_r[wr_addr] <= wr_mask;
      end
   end

   assign rd_vec  = vec_mem_r[rd_addr];
   assign rd_exp  = exp_mem_r[rd_addr];
   assign rd_hold = hold_mem_r[rd_addr];
   assign rd_mask = mask_mem_r[rd_addr];

endmodule

// File: rtl/pattern_player.sv
// Directed stimulus player: loads vec/exp/hold/mask entries in IDLE, then
// replays them to a DUT, checking the response on each slot's last hold cycle.
module pattern_player
   import pattern_player_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int OUT_W  = DEF_OUT_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int HOLD_W = DEF_HOLD_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic [WIDTH-1:0]         load_vec,
   input  logic [OUT_W-1:0]         load_exp,
   input  logic [HOLD_W-1:0]        load_hold,
   input  logic                     load_mask,
   input  logic                     start,
   input  logic                     clear,
   output logic [WIDTH-1:0]         dut_in,
   input  logic [OUT_W-1:0]         dut_out,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH)-1:0] vec_idx,
   output logic [$clog2(DEPTH):0]   err_count,
   output logic                     first_err_valid,
   output logic [$clog2(DEPTH)-1:0] first_err_idx
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   state_t             state_r;
   logic [CNT_W-1:0]   count_r;
   logic [IDX_W-1:0]   wr_ptr_r;
   logic [HOLD_W-1:0]  hold_cnt_r;
   logic [OUT_W-1:0]   cur_exp_r;
   logic               cur_mask_r;
   logic [WIDTH-1:0]   dut_in_r;
   logic [IDX_W-1:0]   vec_idx_r;
   logic [CNT_W-1:0]   err_count_r;
   logic               first_err_valid_r;
   logic [IDX_W-1:0]   first_err_idx_r;
   logic               busy_r;
   logic               done_r;

   logic               wr_en_s;
   logic               full_s;
   logic               last_slot_s;
   logic               mismatch_s;
   logic [IDX_W-1:0]   rd_addr_s;
   logic [WIDTH-1:0]   rd_vec_s;
   logic [OUT_W-1:0]   rd_exp_s;
   logic [HOLD_W-1:0]  rd_hold_s;
   logic               rd_mask_s;

   // Remaining hold cycles after the first one; a hold of 0 behaves like 1
   function automatic logic [HOLD_W-1:0] hold_reload(input logic [HOLD_W-1:0] h);
      if (h == HOLD_W'(0)) begin
         return HOLD_W'(0);
      end else begin
         return h - HOLD_W'(1);
      end
   endfunction

   pattern_table #(
      .WIDTH  (WIDTH),
      .OUT_W  (OUT_W),
      .HOLD_W (HOLD_W),
      .DEPTH  (DEPTH)
   ) u_table (
      .clk     (clk),
      .wr_en   (wr_en_s),
      .wr_addr (wr_ptr_r),
      .wr_vec  (load_vec),
      .wr_exp  (load_exp),
      .wr_hold (load_hold),
      .wr_mask (load_mask),
      .rd_addr (rd_addr_s),
      .rd_vec  (rd_vec_s),
      .rd_exp  (rd_exp_s),
      .rd_hold (rd_hold_s),
      .rd_mask (rd_mask_s)
   );

   // count saturates at DEPTH, a power of two, so its MSB is the full flag
   assign full_s     = count_r[CNT_W-1];
   assign load_ready = (state_r == ST_IDLE) && !full_s;

   // Read address, load strobe and per-slot compare decode
   always_comb begin
      wr_en_s     = (state_r == ST_IDLE) && load_valid && !full_s && !clear;
      last_slot_s = ({1'b0, vec_idx_r} == (count_r - CNT_W'(1)));
      mismatch_s  = !cur_mask_r && (dut_out != cur_exp_r);
      if (state_r == ST_PLAY) begin
         rd_addr_s = vec_idx_r + IDX_W'(1);
      end else begin
         rd_addr_s = IDX_W'(0);
      end
   end

   // Playback FSM with loading, checking and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r           <= ST_IDLE;
         count_r           <= CNT_W'(0);
         wr_ptr_r          <= IDX_W'(0);
         hold_cnt_r        <= HOLD_W'(0);
         cur_exp_r         <= OUT_W'(0);
         cur_mask_r        <= 1'b0;
         dut_in_r          <= WIDTH'(0);
         vec_idx_r         <= IDX_W'(0);
         err_count_r       <= CNT_W'(0);
         first_err_valid_r <= 1'b0;
         first_err_idx_r   <= IDX_W'(0);
         busy_r            <= 1'b0;
         done_r            <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (clear) begin
                  count_r           <= CNT_W'(0);
                  wr_ptr_r          <= IDX_W'(0);
                  err_count_r       <= CNT_W'(0);
                  first_err_valid_r <= 1'b0;
                  first_err_idx_r   <= IDX_W'(0);
               end else begin
                  if (wr_en_s) begin
                     wr_ptr_r <= wr_ptr_r + IDX_W'(1);
                     count_r  <= count_r + CNT_W'(1);
                  end
                  if (start) begin
                     err_count_r       <= CNT_W'(0);
                     first_err_valid_r <= 1'b0;
                     vec_idx_r         <= IDX_W'(0);
                     if (count_r != CNT_W'(0)) begin
                        state_r    <= ST_PLAY;
                        busy_r     <= 1'b1;
                        dut_in_r   <= rd_vec_s;
                        cur_exp_r  <= rd_exp_s;
                        cur_mask_r <= rd_mask_s;
                        hold_cnt_r <= hold_reload(rd_hold_s);
                     end else begin
                        state_r <= ST_END;
                        done_r  <= 1'b1;
                     end
                  end
               end
            end
            ST_PLAY: begin
               if (hold_cnt_r == HOLD_W'(0)) begin
                  if (mismatch_s) begin
                     if (err_count_r != CNT_W'(DEPTH)) begin
                        err_count_r <= err_count_r + CNT_W'(1);
                     end
                     if (!first_err_valid_r) begin
                        first_err_valid_r <= 1'b1;
                        first_err_idx_r   <= vec_idx_r;
                     end
                  end
                  if (last_slot_s) begin
                     state_r <= ST_END;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     vec_idx_r  <= vec_idx_r + IDX_W'(1);
                     dut_in_r   <= rd_vec_s;
                     cur_exp_r  <= rd_exp_s;
                     cur_mask_r <= rd_mask_s;
                     hold_cnt_r <= hold_reload(rd_hold_s);
                  end
               end else begin
                  hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
               end
            end
            ST_END: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign dut_in          = dut_in_r;
   assign busy            = busy_r;
   assign done            = done_r;
   assign vec_idx         = vec_idx_r;
   assign err_count       = err_count_r;
   assign first_err_valid = first_err_valid_r;
   assign first_err_idx   = first_err_idx_r;

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player: table of playback scenarios plus
// hand-written sequences for overflow, hold 0, clear and mid-play reset.
module tb_pattern_player;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_valid;
   logic       load_ready;
   logic [4:0] load_vec;
   logic [0:0] load_exp;
   logic [7:0] load_hold;
   logic       load_mask;
   logic       start;
   logic       clear;
   logic [4:0] dut_in;
   logic [0:0] dut_out;
   logic       busy;
   logic       done;
   logic [2:0] vec_idx;
   logic [3:0] err_count;
   logic       first_err_valid;
   logic [2:0] first_err_idx;

   logic [31:0] wrong_map;
   int          checks   = 0;
   int          failures = 0;

   logic [4:0] m_vec  [8];
   logic [7:0] m_hold [8];
   int         m_cnt;

   typedef struct {
      logic        reload;
      logic [3:0]  mask;
      logic [31:0] wrong;
      int          exp_err;
      logic        exp_fev;
      int          exp_fei;
   } scen_t;

   scen_t      scen [5];
   logic [4:0] base_vec [4];

   always #5 clk = ~clk;

   // Model DUT: parity of the stimulus, inverted for vectors flagged in wrong_map
   assign dut_out = (^dut_in) ^ wrong_map[dut_in];

   pattern_player #(
      .WIDTH(5), .OUT_W(1), .DEPTH(8), .HOLD_W(8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .load_valid      (load_valid),
      .load_ready      (load_ready),
      .load_vec        (load_vec),
      .load_exp        (load_exp),
      .load_hold       (load_hold),
      .load_mask       (load_mask),
      .start           (start),
      .clear           (clear),
      .dut_in          (dut_in),
      .dut_out         (dut_out),
      .busy            (busy),
      .done            (done),
      .vec_idx         (vec_idx),
      .err_count       (err_count),
      .first_err_valid (first_err_valid),
      .first_err_idx   (first_err_idx)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_cnt = 0;
   endtask

   task automatic load_entry(input logic [4:0] v, input logic [7:0] h, input logic m,
                             input logic acc);
      chk("load_ready", 32'(load_ready), 32'(acc));
      load_valid = 1'b1;
      load_vec   = v;
      load_exp   = ^v;
      load_hold  = h;
      load_mask  = m;
      tick();
      load_valid = 1'b0;
      if (acc) begin
         m_vec[m_cnt]  = v;
         m_hold[m_cnt] = h;
         m_cnt++;
      end
   endtask

   task automatic play_check(input int n, input int exp_err, input logic exp_fev,
                             input int exp_fei, input bit pulse_mid);
      int h;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("err_cleared_on_start", 32'(err_count), 32'd0);
      chk("fev_cleared_on_start", 32'(first_err_valid), 32'd0);
      for (int i = 0; i < n; i++) begin
         h = (m_hold[i] == 8'd0) ? 1 : int'(m_hold[i]);
         for (int c = 0; c < h; c++) begin
            chk("dut_in", 32'(dut_in), 32'(m_vec[i]));
            chk("vec_idx", 32'(vec_idx), 32'(i));
            chk("busy", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            if (pulse_mid && i == 1 && c == 0) start = 1'b1;
            tick();
            start = 1'b0;
         end
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_end", 32'(busy), 32'd0);
      chk("dut_in_final", 32'(dut_in), 32'(m_vec[n-1]));
      chk("err_count", 32'(err_count), 32'(exp_err));
      chk("first_err_valid", 32'(first_err_valid), 32'(exp_fev));
      if (exp_fev) chk("first_err_idx", 32'(first_err_idx), 32'(exp_fei));
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("ready_after_end", 32'(load_ready), 32'(m_cnt < 8));
   endtask

   initial begin
      base_vec[0] = 5'b00000;
      base_vec[1] = 5'b10101;
      base_vec[2] = 5'b11011;
      base_vec[3] = 5'b11111;
      scen[0] = '{1'b1, 4'b0000, 32'h0, 0, 1'b0, 0};
      scen[1] = '{1'b0, 4'b0000, 32'h0800_0000, 1, 1'b1, 2};
      scen[2] = '{1'b0, 4'b0000, 32'h0, 0, 1'b0, 0};
      scen[3] = '{1'b1, 4'b0110, 32'h0820_0000, 0, 1'b0, 0};
      scen[4] = '{1'b1, 4'b0000, 32'h8020_0000, 2, 1'b1, 1};

      rst = 1'b1; load_valid = 1'b0; load_vec = 5'd0; load_exp = 1'b0;
      load_hold = 8'd0; load_mask = 1'b0; start = 1'b0; clear = 1'b0;
      wrong_map = 32'h0; m_cnt = 0;
      tick();
      tick();
      chk("rst_dut_in", 32'(dut_in), 32'd0);
      chk("rst_vec_idx", 32'(vec_idx), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_fev", 32'(first_err_valid), 32'd0);
      chk("rst_fei", 32'(first_err_idx), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_load_ready", 32'(load_ready), 32'd1);
      rst = 1'b0;

      // Four-entry table, hold 10: correct, wrong on 2, rerun, masked, wrong on 1 and 3
      for (int s = 0; s < 5; s++) begin
         if (scen[s].reload) begin
            do_clear();
            for (int i = 0; i < 4; i++) load_entry(base_vec[i], 8'd10, scen[s].mask[i], 1'b1);
         end
         wrong_map = scen[s].wrong;
         play_check(4, scen[s].exp_err, scen[s].exp_fev, scen[s].exp_fei, 1'b0);
      end
      wrong_map = 32'h0;

      // clear together with load_valid: clear wins, so start finds an empty table
      clear = 1'b1; load_valid = 1'b1; load_vec = 5'b00111; load_hold = 8'd1;
      tick();
      clear = 1'b0; load_valid = 1'b0; m_cnt = 0;
      chk("clear_err_count", 32'(err_count), 32'd0);
      chk("clear_fev", 32'(first_err_valid), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("clear_wins_done", 32'(done), 32'd1);
      chk("clear_wins_busy", 32'(busy), 32'd0);
      tick();

      // DEPTH+1 loads: ninth refused, playback covers eight
      for (int i = 0; i < 8; i++) load_entry(5'(i + 1), 8'd1, 1'b0, 1'b1);
      chk("full_ready_low", 32'(load_ready), 32'd0);
      load_entry(5'd20, 8'd1, 1'b0, 1'b0);
      play_check(8, 0, 1'b0, 0, 1'b0);

      // hold 0 lasts one cycle; start during PLAY is ignored
      do_clear();
      load_entry(5'b00011, 8'd2, 1'b0, 1'b1);
      load_entry(5'b01100, 8'd0, 1'b0, 1'b1);
      load_entry(5'b10000, 8'd3, 1'b0, 1'b1);
      play_check(3, 0, 1'b0, 0, 1'b1);

      // reset in the middle of entry 1, then start on an empty table
      do_clear();
      for (int i = 0; i < 4; i++) load_entry(base_vec[i], 8'd10, 1'b0, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 15; c++) tick();
      chk("pre_rst_vec_idx", 32'(vec_idx), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_cnt = 0;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_dut_in", 32'(dut_in), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_vec_idx", 32'(vec_idx), 32'd0);
      chk("mid_rst_ready", 32'(load_ready), 32'd1);
      tick();
      chk("post_rst_no_done", 32'(done), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("empty_start_done", 32'(done), 32'd1);
      chk("empty_start_err", 32'(err_count), 32'd0);
      tick();
      chk("empty_done_one_cycle", 32'(done), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
